// File: rtl/dmem_arbiter_if.sv
// Bundle of core, external and memory-side signals
// shared by the data-memory arbiter and its environment.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  core_req_i;
  logic                  core_we_i;
  logic [ADDR_WIDTH-1:0] core_addr_i;
  logic [DATA_WIDTH-1:0] core_wdata_i;
  logic                  core_gnt_o;
  logic                  core_stall_o;
  logic                  core_rvalid_o;
  logic [DATA_WIDTH-1:0] core_rdata_o;

  logic                  ext_req_i;
  logic                  ext_we_i;
  logic [ADDR_WIDTH-1:0] ext_addr_i;
  logic [DATA_WIDTH-1:0] ext_wdata_i;
  logic                  ext_lock_i;
  logic                  ext_gnt_o;
  logic                  ext_rvalid_o;
  logic [DATA_WIDTH-1:0] ext_rdata_o;

  logic                  mem_write_o;
  logic                  mem_read_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  core_req_i, core_we_i,
    input  core_addr_i, core_wdata_i,
    input  ext_req_i, ext_we_i,
    input  ext_addr_i, ext_wdata_i,
    input  ext_lock_i, mem_rdata_i,
    output core_gnt_o, core_stall_o,
    output core_rvalid_o, core_rdata_o,
    output ext_gnt_o, ext_rvalid_o,
    output ext_rdata_o,
    output mem_write_o, mem_read_o,
    output mem_addr_o, mem_wdata_o
  );

  modport master (
    output core_req_i, core_we_i,
    output core_addr_i, core_wdata_i,
    output ext_req_i, ext_we_i,
    output ext_addr_i, ext_wdata_i,
    output ext_lock_i, mem_rdata_i,
    input  core_gnt_o, core_stall_o,
    input  core_rvalid_o, core_rdata_o,
    input  ext_gnt_o, ext_rvalid_o,
    input  ext_rdata_o,
    input  mem_write_o, mem_read_o,
    input  mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin data-memory arbiter between the core
// load/store port and an external port with bounded lock.
module dmem_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_EXT_BURST = 8
) (
  input logic          clk,
  input logic          reset,
  dmem_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_EXT_BURST) + 1;
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_EXT_BURST);
  localparam logic [0:0] UNLOCKED = 1'b0;
  localparam logic [0:0] LOCKED   = 1'b1;

  logic [0:0]            state;
  logic [CW-1:0]         burst_cnt;
  logic                  last_gnt;
  logic                  core_win;
  logic                  ext_win;
  logic                  burst_full;
  logic                  core_rvalid;
  logic                  ext_rvalid;
  logic [DATA_WIDTH-1:0] core_rdata;
  logic [DATA_WIDTH-1:0] ext_rdata;
  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [DATA_WIDTH-1:0] wdata_mux;
  logic                  write_mux;
  logic                  read_mux;

  assign burst_full = (burst_cnt == BURST_MAX);

  // Pick at most one winner; grants are forced low during reset.
  always_comb begin
    core_win = 1'b0;
    ext_win  = 1'b0;
    if (!reset) begin
      if (state == LOCKED) begin
        ext_win  = bus.ext_req_i &
                   ~(burst_full & bus.core_req_i);
        core_win = bus.core_req_i & ~ext_win;
      end else if (bus.core_req_i & bus.ext_req_i) begin
        core_win = last_gnt;
        ext_win  = ~last_gnt;
      end else begin
        core_win = bus.core_req_i;
        ext_win  = bus.ext_req_i;
      end
    end
  end

  // Route the winner's request to the memory; idle bus is all-zero.
  always_comb begin
    write_mux = 1'b0;
    read_mux  = 1'b0;
    addr_mux  = '0;
    wdata_mux = '0;
    if (core_win) begin
      write_mux = bus.core_we_i;
      read_mux  = ~bus.core_we_i;
      addr_mux  = bus.core_addr_i;
      wdata_mux = bus.core_wdata_i;
    end else if (ext_win) begin
      write_mux = bus.ext_we_i;
      read_mux  = ~bus.ext_we_i;
      addr_mux  = bus.ext_addr_i;
      wdata_mux = bus.ext_wdata_i;
    end
  end

  // Lock FSM, burst counter and round-robin history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= UNLOCKED;
      burst_cnt <= '0;
      last_gnt  <= 1'b1;
    end else begin
      if (core_win | ext_win) last_gnt <= ext_win;
      if (!bus.ext_lock_i) begin
        state     <= UNLOCKED;
        burst_cnt <= '0;
      end else if (ext_win) begin
        state <= LOCKED;
        if (state == UNLOCKED) burst_cnt <= CW'(1);
        else if (!burst_full) burst_cnt <= burst_cnt + 1'b1;
      end else if (core_win && state == LOCKED &&
                   bus.ext_req_i) begin
        burst_cnt <= '0;
      end
    end
  end

  // Capture load data for the granted port; rvalid is a 1-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_rvalid <= 1'b0;
      ext_rvalid  <= 1'b0;
      core_rdata  <= '0;
      ext_rdata   <= '0;
    end else begin
      core_rvalid <= core_win & ~bus.core_we_i;
      ext_rvalid  <= ext_win & ~bus.ext_we_i;
      if (core_win & ~bus.core_we_i) core_rdata <= bus.mem_rdata_i;
      if (ext_win & ~bus.ext_we_i) ext_rdata <= bus.mem_rdata_i;
    end
  end

  assign bus.core_gnt_o    = core_win;
  assign bus.ext_gnt_o     = ext_win;
  assign bus.core_stall_o  = bus.core_req_i & ~core_win & ~reset;
  assign bus.core_rvalid_o = core_rvalid;
  assign bus.core_rdata_o  = core_rdata;
  assign bus.ext_rvalid_o  = ext_rvalid;
  assign bus.ext_rdata_o   = ext_rdata;
  assign bus.mem_write_o   = write_mux;
  assign bus.mem_read_o    = read_mux;
  assign bus.mem_addr_o    = addr_mux;
  assign bus.mem_wdata_o   = wdata_mux;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random checks of dmem_arbiter against
// a cycle-level reference model and shadow memory.
module tb_dmem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXB = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  dmem_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_EXT_BURST(MAXB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [31:0] mem [16];

  function automatic logic [31:0] init_word(int i);
    return 32'hA5A5_0000 + 32'(i * 4);
  endfunction

  assign bus.mem_rdata_i = mem[bus.mem_addr_o[5:2]];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    end else if (bus.mem_write_o) begin
      mem[bus.mem_addr_o[5:2]] <= bus.mem_wdata_o;
    end
  end

  int total = 0;
  int bad = 0;
  bit m_locked;
  int m_streak;
  bit m_last;
  bit pc, pe;
  logic [31:0] crd, erd;
  logic [31:0] ref_mem [16];
  int denied_run;

  bit cr, cw, er, ew, el, gc, ge;
  logic [31:0] ca, cd, ea, ed;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_streak = 0;
    m_last = 1'b1;
    pc = 1'b0;
    pe = 1'b0;
    crd = '0;
    erd = '0;
    denied_run = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
  endtask

  task automatic drive_idle();
    bus.core_req_i = 1'b0;
    bus.core_we_i = 1'b0;
    bus.core_addr_i = '0;
    bus.core_wdata_i = '0;
    bus.ext_req_i = 1'b0;
    bus.ext_we_i = 1'b0;
    bus.ext_addr_i = '0;
    bus.ext_wdata_i = '0;
    bus.ext_lock_i = 1'b0;
  endtask

  task automatic chk_all_zero(string tag);
    chk1({tag, "_core_gnt"}, bus.core_gnt_o, 1'b0);
    chk1({tag, "_ext_gnt"}, bus.ext_gnt_o, 1'b0);
    chk1({tag, "_stall"}, bus.core_stall_o, 1'b0);
    chk1({tag, "_core_rvalid"}, bus.core_rvalid_o, 1'b0);
    chk1({tag, "_ext_rvalid"}, bus.ext_rvalid_o, 1'b0);
    chk({tag, "_core_rdata"}, bus.core_rdata_o, 32'h0);
    chk({tag, "_ext_rdata"}, bus.ext_rdata_o, 32'h0);
    chk1({tag, "_mem_write"}, bus.mem_write_o, 1'b0);
    chk1({tag, "_mem_read"}, bus.mem_read_o, 1'b0);
    chk({tag, "_mem_addr"}, bus.mem_addr_o, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    bus.core_req_i = 1'b1;
    reset = 1'b1;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    drive_idle();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic step(
    input bit creq, cwe, input logic [31:0] ca_i, cd_i,
    input bit ereq, ewe, input logic [31:0] ea_i, ed_i,
    input bit lock, output bit gc_o, output bit ge_o
  );
    bit xc, xe, xw, xr;
    logic [31:0] xa, xd;
    @(negedge clk);
    bus.core_req_i = creq;
    bus.core_we_i = cwe;
    bus.core_addr_i = ca_i;
    bus.core_wdata_i = cd_i;
    bus.ext_req_i = ereq;
    bus.ext_we_i = ewe;
    bus.ext_addr_i = ea_i;
    bus.ext_wdata_i = ed_i;
    bus.ext_lock_i = lock;
    #1;
    if (m_locked) begin
      xe = ereq && !(creq && m_streak >= MAXB);
      xc = creq && !xe;
    end else if (creq && ereq) begin
      xc = m_last;
      xe = !m_last;
    end else begin
      xc = creq;
      xe = ereq;
    end
    xw = xc ? cwe : (xe ? ewe : 1'b0);
    xr = xc ? !cwe : (xe ? !ewe : 1'b0);
    xa = xc ? ca_i : (xe ? ea_i : 32'h0);
    xd = xc ? cd_i : (xe ? ed_i : 32'h0);
    chk1("core_gnt", bus.core_gnt_o, xc);
    chk1("ext_gnt", bus.ext_gnt_o, xe);
    chk1("core_stall", bus.core_stall_o, creq && !xc);
    chk1("mem_write", bus.mem_write_o, xw);
    chk1("mem_read", bus.mem_read_o, xr);
    chk("mem_addr", bus.mem_addr_o, xa);
    chk("mem_wdata", bus.mem_wdata_o, xd);
    chk1("core_rvalid", bus.core_rvalid_o, pc);
    chk("core_rdata", bus.core_rdata_o, crd);
    chk1("ext_rvalid", bus.ext_rvalid_o, pe);
    chk("ext_rdata", bus.ext_rdata_o, erd);
    if (creq && !bus.core_gnt_o) denied_run++;
    else denied_run = 0;
    chk1("core_wait_bound", denied_run <= MAXB, 1'b1);
    gc_o = bus.core_gnt_o;
    ge_o = bus.ext_gnt_o;
    pc = xc && !cwe;
    if (pc) crd = ref_mem[ca_i[5:2]];
    pe = xe && !ewe;
    if (pe) erd = ref_mem[ea_i[5:2]];
    if (xc && cwe) ref_mem[ca_i[5:2]] = cd_i;
    if (xe && ewe) ref_mem[ea_i[5:2]] = ed_i;
    if (xc || xe) m_last = xe;
    if (!lock) begin
      m_locked = 1'b0;
      m_streak = 0;
    end else if (xe) begin
      m_streak = m_locked ? ((m_streak < MAXB) ? m_streak + 1 : MAXB) : 1;
      m_locked = 1'b1;
    end else if (xc && m_locked && ereq) begin
      m_streak = 0;
    end
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, gc, ge);
  endtask

  initial begin
    drive_idle();
    model_reset();
    do_reset();

    step(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, gc, ge);
    chk1("load_gnt", gc, 1'b1);
    idle_step();
    chk("load_data", bus.core_rdata_o, init_word(4));

    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 32'h4, 0, 1, 0, 32'h8, 0, 0, gc, ge);
      chk1("alternate", gc, (i % 2) == 0);
    end

    step(0, 0, 0, 0, 1, 1, 32'h20, 32'hDEADBEEF, 0, gc, ge);
    step(1, 0, 32'h20, 0, 0, 0, 0, 0, 0, gc, ge);
    idle_step();
    chk("ld_after_st", bus.core_rdata_o, 32'hDEADBEEF);

    do_reset();
    for (int i = 0; i < 22; i++) begin
      step(1, 0, 32'h0, 0, 1, 0, 32'h3C, 0, 1, gc, ge);
    end

    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 32'h8, 32'h1234, 1, 0, 32'hC, 0, 1, gc, ge);
    end
    step(1, 1, 32'h8, 32'h1234, 1, 0, 32'hC, 0, 0, gc, ge);
    step(1, 1, 32'h8, 32'h1234, 1, 0, 32'hC, 0, 0, gc, ge);
    chk1("unlock_core", gc, 1'b1);

    do_reset();
    @(negedge clk);
    bus.core_req_i = 1'b1;
    bus.core_we_i = 1'b0;
    bus.core_addr_i = 32'h14;
    #1;
    chk1("pre_rst_gnt", bus.core_gnt_o, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    #1;
    chk1("drop_rvalid", bus.core_rvalid_o, 1'b0);
    @(negedge clk);
    drive_idle();
    reset = 1'b0;
    model_reset();
    step(1, 0, 32'h4, 0, 1, 0, 32'h8, 0, 0, gc, ge);
    chk1("first_tie_core", gc, 1'b1);
    idle_step();

    do_reset();
    cr = 0; er = 0; el = 0;
    cw = 0; ew = 0;
    ca = 0; cd = 0; ea = 0; ed = 0;
    for (int i = 0; i < 400; i++) begin
      if (!cr && ($urandom % 4) != 0) begin
        cr = 1;
        cw = 1'($urandom % 2);
        ca = {26'd0, 4'($urandom), 2'b00};
        cd = $urandom;
      end
      if (!er && ($urandom % 3) != 0) begin
        er = 1;
        ew = 1'($urandom % 2);
        ea = {26'd0, 4'($urandom), 2'b00};
        ed = $urandom;
      end
      if (($urandom % 8) == 0) el = ~el;
      step(cr, cw, ca, cd, er, ew, ea, ed, el, gc, ge);
      if (gc) cr = 0;
      if (ge) er = 0;
    end
    idle_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
